cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Completion-side arbiter that shares the NUM_LANES-wide common data bus (CDB) among NUM_REQ functional-unit completion ports. Each requester owns a 1-entry holding register inside the block. Each cycle a round-robin selector grants up to NUM_LANES held results and drives them, registered, onto the CDB that feeds RS wakeup, ROB completion and the map table. A squash input flushes everything in flight.

## Interface
- NUM_REQ, 8: number of FU completion requesters.
- NUM_LANES, 3: CDB broadcast lanes per cycle; must be ≤ NUM_REQ.
- TAG_W, 6: physical-register tag width.
- DATA_W, 32: result width.
- ROB_W, 5: ROB index width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a result.
- req_tag  in  NUM_REQ*TAG_W  destination tag; slice i belongs to requester i.
- req_data  in  NUM_REQ*DATA_W  result value.
- req_rob  in  NUM_REQ*ROB_W  ROB index.
- req_ready  out  NUM_REQ  holding register i can accept this cycle.
- squash  in  1  synchronous flush of held and broadcasting results.
- cdb_valid  out  NUM_LANES  lane j broadcasting.
- cdb_tag  out  NUM_LANES*TAG_W  lane j tag.
- cdb_data  out  NUM_LANES*DATA_W  lane j value.
- cdb_rob  out  NUM_LANES*ROB_W  lane j ROB index.

## Operation
- State:
  - hold_v[i] plus hold_tag/data/rob[i] for each requester.
  - rr_ptr, $clog2(NUM_REQ) bits.
  - Registered CDB lane outputs.
- Transfer: requester i hands over a result at an edge where req_valid[i] && req_ready[i]. The result is written into hold[i] and hold_v[i] is set.
- req_ready[i] = rst && !squash && (!hold_v[i] || grant[i]).
  - Depends only on state and squash, never on req_valid, so there is no combinational loop.
- Arbitration (combinational on hold_v and rr_ptr):
  - Scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - The first NUM_LANES held entries are granted, in scan order, to lanes 0, 1, 2.
  - Lanes are filled densely from lane 0; unused lanes are invalid.
- On each edge without squash:
  - Granted entries load into the CDB registers.
  - Each granted hold_v clears, unless a new transfer refills it the same edge; refill has priority and hold_v stays 1.
  - Ungranted held entries stay unchanged.
  - Lanes with no grant: cdb_valid = 0, and cdb_tag/data/rob hold their previous values.
- rr_ptr update:
  - If any grant: rr_ptr ← (index of last granted requester + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
  - Guarantees that any held entry is broadcast within ceil(NUM_REQ/NUM_LANES) cycles.
- Squash (synchronous, single cycle):
  - Next edge: all hold_v ← 0 and all cdb_valid ← 0.
  - Requests presented during the squash cycle are dropped (req_ready = 0).
  - rr_ptr is unchanged.
- Reset (rst low, asynchronous, may occur mid-operation):
  - hold_v = 0, rr_ptr = 0.
  - cdb_valid = 0; cdb_tag, cdb_data, cdb_rob = 0.
  - req_ready = 0 while rst is low; all 1 in the first cycle after release.
- The block performs no tag/ROB checking; duplicate tags are broadcast as given.

## Timing
- Latency:
  - Request accepted at edge k.
  - Eligible for grant during cycle k→k+1.
  - cdb_valid visible after edge k+1.
  - Minimum 1 cycle from handshake to broadcast; 2 cycles from the first req_valid.
- Throughput: 1 result per requester per cycle while that requester is granted every cycle.
  - Back-to-back transfers are accepted because of refill-on-grant.
- CDB outputs are registered and drive 1-cycle pulses; there is no backpressure from consumers.
- squash and an incoming transfer on the same edge: squash wins.

## Configuration
- CDB_ARB_PERF_EN defined adds two outputs, both reset to 0 and saturating at all-ones:
  - perf_bcast_cnt (out, 32): running count of valid lane broadcasts, incremented by popcount(cdb_valid) each cycle.
  - perf_conflict_cnt (out, 32): count of cycles where popcount(hold_v) > NUM_LANES.
- CDB_ARB_PERF_EN undefined: the ports and counters are absent and the rest of the behaviour is identical.

## Test plan
- Reset: drive rst low mid-stream with hold_v = 8'hFF → cdb_valid = 0 immediately, req_ready = 0; after release, req_ready = 8'hFF and rr_ptr = 0.
- Single request: req 2, tag 6'd9, data 32'hDEAD, rob 5'd4, 1 cycle → next edge lane 0 valid with tag 9, DEAD, rob 4; lanes 1–2 invalid; cycle after, cdb_valid = 0.
- Oversubscription: all 8 requesters valid for one cycle with rr_ptr = 0, then idle:
  - Broadcasts are {0,1,2}, then {3,4,5}, then {6,7}.
  - rr_ptr ends at 0.
  - Every requester is broadcast exactly once.
- Fairness: requesters 0–3 held continuously valid → grant sets rotate {0,1,2}, {3,0,1}, {2,3,0}; no requester waits more than 2 cycles.
- Refill: requester 5 alone holds req_valid high for 4 cycles with tags 1–4 → tags 1, 2, 3, 4 appear on lane 0 on 4 consecutive cycles; req_ready[5] stays 1.
- Squash: 6 entries held plus 3 broadcasting, squash pulsed together with a new req 7 → next cycle cdb_valid = 0, hold_v = 0, req 7 never broadcast. With CDB_ARB_PERF_EN, perf_bcast_cnt counts the pre-squash lanes only.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that drains NUM_REQ one-entry holding registers onto a NUM_LANES-wide registered CDB.
// Optional feature macro: CDB_ARB_PERF_EN adds saturating broadcast/conflict performance counters.
module cdb_arbiter #(
  parameter int NUM_REQ   = 8,
  parameter int NUM_LANES = 3,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32,
  parameter int ROB_W     = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*ROB_W-1:0]    req_rob,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        squash,
  output logic [NUM_LANES-1:0]        cdb_valid,
  output logic [NUM_LANES*TAG_W-1:0]  cdb_tag,
  output logic [NUM_LANES*DATA_W-1:0] cdb_data,
  output logic [NUM_LANES*ROB_W-1:0]  cdb_rob
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0]                 perf_bcast_cnt,
  output logic [31:0]                 perf_conflict_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] hold_v;
  logic [TAG_W-1:0]   hold_tag  [NUM_REQ];
  logic [DATA_W-1:0]  hold_data [NUM_REQ];
  logic [ROB_W-1:0]   hold_rob  [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;

  logic [NUM_REQ-1:0]   grant;
  logic [NUM_LANES-1:0] lane_v;
  logic [PTR_W-1:0]     lane_idx [NUM_LANES];
  logic [PTR_W-1:0]     next_ptr;
  logic [NUM_REQ-1:0]   accept;

  // Handshake: a result moves into hold[i] on an edge where req_valid[i] && req_ready[i].
  // req_ready never looks at req_valid; a granted slot can be refilled on the same edge it drains.
  assign req_ready = {NUM_REQ{rst & ~squash}} & (~hold_v | grant);
  assign accept    = req_valid & req_ready;

  always_comb begin : arb
    int cnt;
    int sum;
    logic [PTR_W-1:0] idx;
    grant    = '0;
    lane_v   = '0;
    next_ptr = rr_ptr;
    for (int j = 0; j < NUM_LANES; j++) lane_idx[j] = '0;
    cnt = 0;
    sum = 0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = PTR_W'(sum);
      if (hold_v[idx] && (cnt < NUM_LANES)) begin
        grant[idx] = 1'b1;
        for (int j = 0; j < NUM_LANES; j++) begin
          if (j == cnt) begin
            lane_v[j]   = 1'b1;
            lane_idx[j] = idx;
          end
        end
        next_ptr = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        cnt = cnt + 1;
      end
    end
  end

  // Payload storage needs no reset: it is only read once hold_v marks it written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        hold_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
        hold_data[i] <= req_data[i*DATA_W +: DATA_W];
        hold_rob[i]  <= req_rob[i*ROB_W +: ROB_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v    <= '0;
      rr_ptr    <= '0;
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_rob   <= '0;
    end else if (squash) begin
      hold_v    <= '0;
      cdb_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) hold_v[i] <= 1'b1;
        else if (grant[i]) hold_v[i] <= 1'b0;
      end
      cdb_valid <= lane_v;
      for (int j = 0; j < NUM_LANES; j++) begin
        if (lane_v[j]) begin
          cdb_tag[j*TAG_W +: TAG_W]    <= hold_tag[lane_idx[j]];
          cdb_data[j*DATA_W +: DATA_W] <= hold_data[lane_idx[j]];
          cdb_rob[j*ROB_W +: ROB_W]    <= hold_rob[lane_idx[j]];
        end
      end
      rr_ptr <= next_ptr;
    end
  end

`ifdef CDB_ARB_PERF_EN
  logic [31:0] bcast_inc;
  logic [31:0] held_cnt;
  logic [32:0] bcast_sum;

  always_comb begin
    bcast_inc = '0;
    held_cnt  = '0;
    for (int j = 0; j < NUM_LANES; j++) bcast_inc = bcast_inc + 32'(cdb_valid[j]);
    for (int i = 0; i < NUM_REQ; i++) held_cnt = held_cnt + 32'(hold_v[i]);
    bcast_sum = {1'b0, perf_bcast_cnt} + {1'b0, bcast_inc};
  end

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_bcast_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      perf_bcast_cnt <= bcast_sum[32] ? '1 : bcast_sum[31:0];
      if ((held_cnt > 32'(NUM_LANES)) && (perf_conflict_cnt != '1))
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: ring-scan reference model compared every cycle, plus directed literal checks.
// Build with CDB_ARB_PERF_EN defined to also check the performance counters.
module tb_cdb_arbiter;
  localparam int NR = 8;
  localparam int NL = 3;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int RW = 5;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*TW-1:0] req_tag;
  logic [NR*DW-1:0] req_data;
  logic [NR*RW-1:0] req_rob;
  logic [NR-1:0]    req_ready;
  logic             squash;
  logic [NL-1:0]    cdb_valid;
  logic [NL*TW-1:0] cdb_tag;
  logic [NL*DW-1:0] cdb_data;
  logic [NL*RW-1:0] cdb_rob;
`ifdef CDB_ARB_PERF_EN
  logic [31:0]      perf_bcast_cnt;
  logic [31:0]      perf_conflict_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data), .req_rob(req_rob),
    .req_ready(req_ready), .squash(squash),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_rob(cdb_rob)
`ifdef CDB_ARB_PERF_EN
    , .perf_bcast_cnt(perf_bcast_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NR-1:0] m_hv;
  logic [TW-1:0] m_tag  [NR];
  logic [DW-1:0] m_data [NR];
  logic [RW-1:0] m_rob  [NR];
  int            m_ptr;
  logic [NL-1:0] e_valid;
  logic [TW-1:0] e_tag  [NL];
  logic [DW-1:0] e_data [NL];
  logic [RW-1:0] e_rob  [NL];
  logic [31:0]   e_bcast;
  logic [31:0]   e_conf;
  logic [NR-1:0] m_gm;
  logic [NR-1:0] m_acc;
  int            m_n;
  int            m_i;
  int            m_last;

  // Walk the ring from ptr and take the first NL occupied slots.
  function automatic logic [NR-1:0] grant_mask(input logic [NR-1:0] hv, input int ptr);
    logic [NR-1:0] g;
    int taken;
    g = '0;
    taken = 0;
    for (int k = 0; k < NR; k++) begin
      if (hv[(ptr + k) % NR] && taken < NL) begin
        g[(ptr + k) % NR] = 1'b1;
        taken++;
      end
    end
    return g;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hv = '0;
      m_ptr = 0;
      e_valid = '0;
      for (int j = 0; j < NL; j++) begin
        e_tag[j] = '0; e_data[j] = '0; e_rob[j] = '0;
      end
      e_bcast = '0;
      e_conf = '0;
    end else begin
      e_bcast = e_bcast + 32'($countones(e_valid));
      if ($countones(m_hv) > NL) e_conf = e_conf + 32'd1;
      if (squash) begin
        m_hv = '0;
        e_valid = '0;
      end else begin
        m_gm  = grant_mask(m_hv, m_ptr);
        m_acc = req_valid & (~m_hv | m_gm);
        m_n = 0;
        m_last = -1;
        e_valid = '0;
        for (int k = 0; k < NR; k++) begin
          m_i = (m_ptr + k) % NR;
          if (m_gm[m_i]) begin
            e_valid[m_n] = 1'b1;
            e_tag[m_n]   = m_tag[m_i];
            e_data[m_n]  = m_data[m_i];
            e_rob[m_n]   = m_rob[m_i];
            m_n++;
            m_last = m_i;
          end
        end
        if (m_last >= 0) m_ptr = (m_last + 1) % NR;
        for (int i = 0; i < NR; i++) begin
          if (m_acc[i]) begin
            m_hv[i]   = 1'b1;
            m_tag[i]  = req_tag[i*TW +: TW];
            m_data[i] = req_data[i*DW +: DW];
            m_rob[i]  = req_rob[i*RW +: RW];
          end else if (m_gm[i]) begin
            m_hv[i] = 1'b0;
          end
        end
      end
    end
  end

  // Compare on the falling edge: state has settled and inputs for the next edge are applied.
  always @(negedge clk) begin
    logic [NR-1:0] exp_ready;
    exp_ready = (rst && !squash) ? (~m_hv | grant_mask(m_hv, m_ptr)) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("cdb_valid", 64'(cdb_valid), 64'(e_valid));
    for (int j = 0; j < NL; j++) begin
      check("cdb_tag",  64'(cdb_tag[j*TW +: TW]),  64'(e_tag[j]));
      check("cdb_data", 64'(cdb_data[j*DW +: DW]), 64'(e_data[j]));
      check("cdb_rob",  64'(cdb_rob[j*RW +: RW]),  64'(e_rob[j]));
    end
`ifdef CDB_ARB_PERF_EN
    check("perf_bcast_cnt",    64'(perf_bcast_cnt),    64'(e_bcast));
    check("perf_conflict_cnt", 64'(perf_conflict_cnt), 64'(e_conf));
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d,
                         input logic [RW-1:0] r);
    req_valid[i]         = 1'b1;
    req_tag[i*TW +: TW]  = t;
    req_data[i*DW +: DW] = d;
    req_rob[i*RW +: RW]  = r;
  endtask

  task automatic check_lanes(input string name, input logic [NL-1:0] v,
                             input int t0, input int t1, input int t2);
    int t [NL];
    t[0] = t0; t[1] = t1; t[2] = t2;
    check({name, "_valid"}, 64'(cdb_valid), 64'(v));
    for (int j = 0; j < NL; j++)
      if (v[j]) check({name, "_tag"}, 64'(cdb_tag[j*TW +: TW]), 64'(t[j]));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0; squash = 1'b0;
    req_valid = '0; req_tag = '0; req_data = '0; req_rob = '0;
    repeat (2) @(posedge clk);
    #3;
    check("reset_ready", 64'(req_ready), 64'h0);
    check("reset_cdb_valid", 64'(cdb_valid), 64'h0);
    rst = 1'b1;
    #1;
    check("post_reset_ready", 64'(req_ready), 64'hFF);
    #2;

    // single request on requester 2
    set_req(2, 6'd9, 32'hDEAD, 5'd4);
    step();
    req_valid = '0;
    check("single_not_yet", 64'(cdb_valid), 64'h0);
    step();
    check("single_valid", 64'(cdb_valid), 64'b001);
    check("single_tag",  64'(cdb_tag[0 +: TW]),  64'd9);
    check("single_data", 64'(cdb_data[0 +: DW]), 64'hDEAD);
    check("single_rob",  64'(cdb_rob[0 +: RW]),  64'd4);
    step();
    check("single_after", 64'(cdb_valid), 64'h0);

    // fill every slot, keep them full, then reset mid-stream
    for (int i = 0; i < NR; i++) set_req(i, TW'(i), 32'h100 + i, RW'(i));
    step();
    step();
    check("pre_reset_bcast", 64'(cdb_valid), 64'b111);
    rst = 1'b0;
    #1;
    check("async_reset_cdb", 64'(cdb_valid), 64'h0);
    check("async_reset_ready", 64'(req_ready), 64'h0);
    check("async_reset_tag", 64'(cdb_tag), 64'h0);
    req_valid = '0;
    step();
    rst = 1'b1;
    #1;
    check("release_ready", 64'(req_ready), 64'hFF);
    step();
    check("release_idle", 64'(cdb_valid), 64'h0);

    // oversubscription from rr_ptr = 0
    for (int i = 0; i < NR; i++) set_req(i, TW'(i), 32'hA0 + i, RW'(i));
    step();
    req_valid = '0;
    step(); check_lanes("over1", 3'b111, 0, 1, 2);
    step(); check_lanes("over2", 3'b111, 3, 4, 5);
    step(); check_lanes("over3", 3'b011, 6, 7, 0);
    step(); check("over_idle", 64'(cdb_valid), 64'h0);
    // pointer back at 0: requester 0 must precede requester 7
    set_req(7, 6'd47, 32'h7, 5'd7);
    set_req(0, 6'd40, 32'h0, 5'd0);
    step();
    req_valid = '0;
    step(); check_lanes("ptr_wrap", 3'b011, 40, 47, 0);

    // fairness: requesters 0..3 continuously valid
    for (int i = 0; i < 4; i++) set_req(i, TW'(i), 32'hF0 + i, RW'(i));
    step();
    step(); check_lanes("fair1", 3'b111, 0, 1, 2);
    step(); check_lanes("fair2", 3'b111, 3, 0, 1);
    step(); check_lanes("fair3", 3'b111, 2, 3, 0);
    req_valid = '0;
    repeat (4) step();
    check("fair_drained", 64'(cdb_valid), 64'h0);

    // refill: requester 5 back-to-back, tags 1..4
    for (int t = 1; t <= 4; t++) begin
      set_req(5, TW'(t), 32'h5000 + t, RW'(t));
      check("refill_ready", 64'(req_ready[5]), 64'h1);
      step();
      if (t > 1) check_lanes("refill", 3'b001, t - 1, 0, 0);
    end
    req_valid = '0;
    step(); check_lanes("refill_last", 3'b001, 4, 0, 0);
    step(); check("refill_idle", 64'(cdb_valid), 64'h0);

    // squash with six held and three broadcasting, plus a fresh request on 7
    for (int i = 0; i < 7; i++) set_req(i, TW'(10 + i), 32'h7000 + i, RW'(i));
    step();
    req_valid = '0;
    set_req(6, 6'd26, 32'h7106, 5'd6);
    set_req(0, 6'd20, 32'h7100, 5'd0);
    step();
    check_lanes("pre_squash", 3'b111, 16, 10, 11);
    req_valid = '0;
    squash = 1'b1;
    set_req(7, 6'd63, 32'hBAD, 5'd31);
    #1;
    check("squash_ready", 64'(req_ready), 64'h0);
    #1;
    step();
    squash = 1'b0;
    req_valid = '0;
    check("squash_cdb", 64'(cdb_valid), 64'h0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("squash_quiet", 64'(cdb_valid), 64'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
